// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Brief    : Round-robin sharing of an HD44780 8-bit bus between two requesters,
//            with E-pulse/wait sequencing. Macro LCD_ARB_INIT_EN adds the
//            power-on init sequence; undefined, reset lands directly in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter #(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned INIT_WAIT1_CYC = 250000,
  parameter int unsigned INIT_WAIT2_CYC = 8000,
  parameter int unsigned E_CYC          = 12,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_valid_i,
  input  logic [1:0]  req_rs_i,
  input  logic [15:0] req_data_i,
  output logic [1:0]  req_ready_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic        busy_o,
  output logic        init_done_o
);

`ifdef LCD_ARB_INIT_EN
  localparam logic C_INIT_EN = 1'b1;
`else
  localparam logic C_INIT_EN = 1'b0;
`endif

  localparam logic [19:0] C_PWRUP_LIM = 20'(POWERUP_CYC);
  localparam logic [19:0] C_E_LIM     = 20'(E_CYC);
  localparam logic [19:0] C_CMD_LIM   = 20'(CMD_WAIT_CYC);
  localparam logic [19:0] C_CLEAR_LIM = 20'(CLEAR_WAIT_CYC);
  localparam logic [2:0]  C_LAST_INIT = 3'd6;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_EHIGH = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        ptr_q, ptr_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        e_q, e_d;
  logic [1:0]  ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        init_done_q, init_done_d;
  logic [19:0] wait_lim;
  logic        gnt;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h38;
      3'd4:             init_byte = 8'h06;
      3'd5:             init_byte = 8'h0C;
      default:          init_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [19:0] init_wait(input logic [2:0] idx);
    case (idx)
      3'd0:             init_wait = 20'(INIT_WAIT1_CYC);
      3'd1, 3'd2:       init_wait = 20'(INIT_WAIT2_CYC);
      3'd3, 3'd4, 3'd5: init_wait = C_CMD_LIM;
      default:          init_wait = C_CLEAR_LIM;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= C_INIT_EN ? S_PWRUP : S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= 1'b1;
      rs_q        <= 1'b0;
      data_q      <= '0;
      e_q         <= 1'b0;
      ready_q     <= '0;
      busy_q      <= C_INIT_EN;
      init_done_q <= ~C_INIT_EN;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      e_q         <= e_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  // Init writes use their own wait table; user writes pick clear/home vs ordinary.
  always_comb begin
    if (!init_done_q)
      wait_lim = init_wait(idx_q);
    else if (!rs_q && (data_q == 8'h01 || data_q == 8'h02))
      wait_lim = C_CLEAR_LIM;
    else
      wait_lim = C_CMD_LIM;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ready_d     = '0;
    init_done_d = init_done_q;
    gnt         = (req_valid_i == 2'b11) ? ~ptr_q : req_valid_i[1];

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == C_PWRUP_LIM) begin
          cnt_d   = '0;
          idx_d   = '0;
          rs_d    = 1'b0;
          data_d  = init_byte(3'd0);
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_IDLE: begin
        if (|req_valid_i) begin
          ptr_d   = gnt;
          rs_d    = req_rs_i[gnt];
          data_d  = gnt ? req_data_i[15:8] : req_data_i[7:0];
          ready_d = gnt ? 2'b10 : 2'b01;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_EHIGH;
      S_EHIGH: begin
        if (cnt_q == C_E_LIM) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_lim) begin
          cnt_d = '0;
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == C_LAST_INIT) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            data_d  = init_byte(idx_q + 3'd1);
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    e_d    = (state_d == S_EHIGH);
    busy_d = (state_d != S_IDLE);
  end

  assign req_ready_o = ready_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_e_o     = e_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;

endmodule
`default_nettype wire
